ofdm_cp_insert: RTL and testbench
=================================

# ofdm_cp_insert

Cyclic-prefix inserter: the stage after the OFDM symbol builder / IFFT. It accepts one complex symbol of OFDM_SIZE time-domain samples per sop and buffers it in a two-bank ping-pong RAM. It then emits the last CP_LEN samples (the prefix) followed by the full symbol, giving OFDM_SIZE+CP_LEN samples per symbol toward the DAC/framer. While one bank is being filled, the other bank is played out.

## Interface
- OFDM_SIZE, 1024, samples per symbol; power of two.
- CP_LEN, 256, prefix length; 1 ≤ CP_LEN ≤ OFDM_SIZE.
- clk  in  1  single clock, all logic on rising edge.
- res  in  1  asynchronous, active-low reset (res=0 resets immediately).
- en  in  1  global enable; en=0 freezes all state.
- valid_in  in  1  input sample qualifier.
- sop_in  in  1  first sample of a symbol; meaningful only with valid_in.
- i_in, q_in  in  16 signed  input sample.
- ready_in  in  1  downstream can take a sample this cycle.
- ready_out  out  1  upstream may present a sample (write bank free).
- valid_out  out  1  output sample qualifier.
- sop_out  out  1  first prefix sample of a symbol.
- eop_out  out  1  last body sample of a symbol.
- i_out, q_out  out  16 signed  output sample.
- sync_err  out  1  one-cycle pulse on a resync.

## Operation
- Storage: 2 banks × OFDM_SIZE × 32 bits ({i,q}). Synchronous read, 1-cycle read latency.
- Ownership flags full[1:0], write bank pointer wb, read bank pointer rb. All reset to 0.
- ready_out = en & ~full[wb] (combinational from registers).
- An input sample is accepted when en & valid_in & ready_out.
- Write FSM, W_IDLE:
  - Accepted sample with sop_in: write address 0, wr_cnt←1, go to W_FILL.
  - Accepted sample without sop_in: discarded.
- Write FSM, W_FILL:
  - Accepted sample without sop_in: write at wr_cnt, wr_cnt+1.
  - Accepted sample with sop_in while wr_cnt≠0: resync. Write it at address 0, wr_cnt←1, pulse sync_err. The partial symbol is lost.
  - Sample written at OFDM_SIZE-1: set full[wb], toggle wb, go to W_IDLE.
- Read FSM, R_IDLE: when full[rb], go to R_CP with rd_cnt←0.
- Read FSM, progress: advances only in cycles with en & ready_in.
  - R_CP reads address OFDM_SIZE-CP_LEN+rd_cnt, for rd_cnt = 0..CP_LEN-1.
  - R_BODY reads address rd_cnt, for rd_cnt = 0..OFDM_SIZE-1.
- End of R_BODY (read of address OFDM_SIZE-1 issued): clear full[rb] and toggle rb.
  - If the other bank is already full, go directly to R_CP with no idle cycle.
  - Otherwise go to R_IDLE.
- Simultaneous full set (writer) and full clear (reader) always target different banks; both take effect.
- Counter widths: $clog2(OFDM_SIZE+1) bits; addresses $clog2(OFDM_SIZE) bits. Prefix address arithmetic is modulo OFDM_SIZE.
- Data is passed bit-exact; no scaling or saturation.

## Timing
- Reset values: ready_out 1 (with en=1), valid_out 0, sop_out 0, eop_out 0, i_out 0, q_out 0, sync_err 0. Both FSMs start in their idle states.
- Reset mid-operation discards both banks' contents logically; RAM contents need not be cleared.
- Output register: valid_out is high in the cycle after a read was issued. It is low in every cycle after one with no read issued, including cycles where ready_in=0, en=0, or the reader is in R_IDLE.
- sop_out is high with the sample read at rd_cnt=0 in R_CP. eop_out is high with the sample read at address OFDM_SIZE-1 in R_BODY.
- Latency: for a symbol arriving while the reader is idle and ready_in is held 1:
  - valid_out/sop_out rise on the 2nd rising edge after the edge that accepted the final input sample.
  - Output then runs OFDM_SIZE+CP_LEN consecutive cycles.
- Throughput: output costs OFDM_SIZE+CP_LEN cycles per symbol. With continuous input, ready_out deasserts when both banks are full. It reasserts the cycle after the reader clears a flag.
- en=0: no accept, no read, valid_out=0 next cycle; all counters hold.
- sync_err is high for exactly one cycle, the cycle after the resyncing sample edge.

## Test plan
Bench parameters: OFDM_SIZE=16, CP_LEN=4 unless stated. Input sample k is i=k, q=-k.
- Single symbol, ready_in=1: output i = 12,13,14,15,0,1,…,15 (20 samples), q = −i. sop_out on the first sample, eop_out on the last. First valid_out 2 edges after input sample 15 is accepted.
- Three back-to-back symbols at full input rate, symbol n offset by 100n: ready_out drops after symbol 2 is buffered; no input sample is lost or duplicated. Output is 60 contiguous valid cycles with sop every 20 samples.
- ready_in random 50% during playout: the output sequence is identical to test 1. valid_out is never high in a cycle following ready_in=0.
- sop_in re-asserted at input sample 7: sync_err pulses once. Output is the new symbol only, beginning with i = 12 + new offset.
- res pulled low during output sample 9, released, then a new symbol is sent: all outputs 0 while res=0. The new symbol plays out cleanly with no residue of the old symbol.
- CP_LEN=16: output is 0..15 twice (32 samples); sop on the first sample, eop on the last.

Source files
------------

// File: rtl/ofdm_cp_insert.sv
// ofdm_cp_insert: cyclic-prefix inserter placed after the IFFT.
// Each symbol of OFDM_SIZE samples is buffered in one bank of a two-bank
// ping-pong RAM. The full bank is then played out as its last CP_LEN samples
// (the prefix) followed by the whole symbol. The writer fills the other bank
// in parallel.
//
// Ports
//   clk, res          clock; asynchronous active-low reset
//   en                global enable, 0 freezes all state
//   valid_in, sop_in  input qualifier / first sample of a symbol
//   i_in, q_in        input sample (signed 16 bit)
//   ready_in          downstream accepts a sample this cycle
//   ready_out         the write bank is free, so upstream may send
//   valid_out         output qualifier, registered
//   sop_out, eop_out  first prefix sample / last body sample
//   i_out, q_out      output sample, bit-exact copy of the input
//   sync_err          one-cycle pulse when a sop restarts a partial symbol
module ofdm_cp_insert #(
  parameter int OFDM_SIZE = 1024,
  parameter int CP_LEN    = 256
) (
  input  logic               clk,
  input  logic               res,
  input  logic               en,
  input  logic               valid_in,
  input  logic               sop_in,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  input  logic               ready_in,
  output logic               ready_out,
  output logic               valid_out,
  output logic               sop_out,
  output logic               eop_out,
  output logic signed [15:0] i_out,
  output logic signed [15:0] q_out,
  output logic               sync_err
);
  localparam int CW = $clog2(OFDM_SIZE + 1);
  localparam int AW = $clog2(OFDM_SIZE);

  localparam logic [CW-1:0] CNT_LAST = CW'(OFDM_SIZE - 1);
  localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
  localparam logic [AW-1:0] ADR_LAST = AW'(OFDM_SIZE - 1);
  // The prefix starts this far into the stored symbol. The AW-bit add wraps,
  // which gives the modulo-OFDM_SIZE addressing for free.
  localparam logic [AW-1:0] CP_BASE  = AW'(OFDM_SIZE - CP_LEN);

  typedef enum logic       {W_IDLE, W_FILL}       wst_t;
  typedef enum logic [1:0] {R_IDLE, R_CP, R_BODY} rst_t;

  wst_t          wst_q, wst_d;
  rst_t          rst_q, rst_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]    full_q, full_d;
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic          valid_q, valid_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          sync_q, sync_d;
  logic [31:0]   dout_q;

  logic          accept, wr_en, resync, set_full, clr_full, rd_issue;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [31:0]   mem [2*OFDM_SIZE];

  assign ready_out = en & ~full_q[wb_q];
  assign accept    = en & valid_in & ready_out;

  // Writer
  always_comb begin
    wst_d    = wst_q;
    wr_cnt_d = wr_cnt_q;
    wr_en    = 1'b0;
    wr_addr  = '0;
    resync   = 1'b0;
    set_full = 1'b0;
    case (wst_q)
      W_IDLE: begin
        // Samples arriving without a sop are dropped until the next one.
        if (accept && sop_in) begin
          wr_en    = 1'b1;
          wr_cnt_d = CW'(1);
          wst_d    = W_FILL;
        end
      end
      W_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (sop_in && wr_cnt_q != '0) begin
            // A new symbol starts over the partial one.
            resync   = 1'b1;
            wr_cnt_d = CW'(1);
          end else begin
            wr_addr  = wr_cnt_q[AW-1:0];
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      default: wst_d = W_IDLE;
    endcase
    if (wr_en && wr_addr == ADR_LAST) begin
      set_full = 1'b1;
      wr_cnt_d = '0;
      wst_d    = W_IDLE;
    end
  end

  // Reader
  assign rd_issue = en & ready_in & (rst_q != R_IDLE);

  always_comb begin
    rst_d    = rst_q;
    rd_cnt_d = rd_cnt_q;
    rd_addr  = '0;
    clr_full = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    case (rst_q)
      R_IDLE: begin
        if (en && full_q[rb_q]) begin
          rst_d    = R_CP;
          rd_cnt_d = '0;
        end
      end
      R_CP: begin
        rd_addr = CP_BASE + rd_cnt_q[AW-1:0];
        if (rd_issue) begin
          sop_d = (rd_cnt_q == '0);
          if (rd_cnt_q == CP_LAST) begin
            rst_d    = R_BODY;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
      R_BODY: begin
        rd_addr = rd_cnt_q[AW-1:0];
        if (rd_issue) begin
          if (rd_cnt_q == CNT_LAST) begin
            eop_d    = 1'b1;
            clr_full = 1'b1;
            rd_cnt_d = '0;
            // Chain straight into the next symbol when it is already waiting.
            rst_d    = full_q[~rb_q] ? R_CP : R_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  // Set and clear always hit different banks, so both can apply in one cycle.
  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wb_q] = 1'b1;
    if (clr_full) full_d[rb_q] = 1'b0;
    wb_d    = wb_q ^ set_full;
    rb_d    = rb_q ^ clr_full;
    valid_d = rd_issue;
    sync_d  = resync;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wst_q    <= W_IDLE;
      rst_q    <= R_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      full_q   <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      wst_q    <= wst_d;
      rst_q    <= rst_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q   <= full_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      sync_q   <= sync_d;
    end
  end

  // The writer only uses a bank whose full flag is clear and the reader only
  // uses a bank whose flag is set, so the two ports never share a bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wb_q, wr_addr}] <= {i_in, q_in};
  end

  // Synchronous read port. It doubles as the output data register.
  always_ff @(posedge clk or negedge res) begin
    if (!res)          dout_q <= '0;
    else if (rd_issue) dout_q <= mem[{rb_q, rd_addr}];
  end

  assign valid_out = valid_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
  assign sync_err  = sync_q;
  assign i_out     = dout_q[31:16];
  assign q_out     = dout_q[15:0];

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// tb_ofdm_cp_insert: randomized bench for ofdm_cp_insert.
// dut_a uses OFDM_SIZE=16 and CP_LEN=4. dut_b uses OFDM_SIZE=16 and CP_LEN=16.
// A symbol-level model rebuilds each accepted symbol from the input stream.
// It queues the expected prefix+body samples for that symbol, and a monitor
// compares every valid output sample against the head of that queue.
module tb_ofdm_cp_insert;
  localparam int N = 16;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic en = 1'b1;
  logic sop_in = 1'b0;
  logic ready_in = 1'b1;
  logic va = 1'b0;
  logic vb = 1'b0;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic rdy_a, vo_a, so_a, eo_a, se_a;
  logic rdy_b, vo_b, so_b, eo_b, se_b;
  logic signed [15:0] io_a, qo_a, io_b, qo_b;

  always #5 clk = ~clk;

  ofdm_cp_insert #(.OFDM_SIZE(N), .CP_LEN(4)) dut_a (
    .clk(clk), .res(res), .en(en), .valid_in(va), .sop_in(sop_in),
    .i_in(i_in), .q_in(q_in), .ready_in(ready_in), .ready_out(rdy_a),
    .valid_out(vo_a), .sop_out(so_a), .eop_out(eo_a),
    .i_out(io_a), .q_out(qo_a), .sync_err(se_a));

  ofdm_cp_insert #(.OFDM_SIZE(N), .CP_LEN(16)) dut_b (
    .clk(clk), .res(res), .en(en), .valid_in(vb), .sop_in(sop_in),
    .i_in(i_in), .q_in(q_in), .ready_in(ready_in), .ready_out(rdy_b),
    .valid_out(vo_b), .sop_out(so_b), .eop_out(eo_b),
    .i_out(io_b), .q_out(qo_b), .sync_err(se_b));

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        sop;
    logic        eop;
  } smp_t;

  smp_t        qa[$];
  smp_t        qb[$];
  int          cnt[2];
  logic [31:0] sbuf[2][N];
  int n_tests = 0, n_fail = 0, cyc = 0;
  int last_acc = 0, first_a = -1, seen_a = 0, run = 0, maxrun = 0;
  int sync_seen = 0, sync_cyc = -1, exp_sync_n = 0, exp_sync_cyc = -2, stalls = 0;
  logic prev_ok = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Symbol-level reference: assemble symbols from sop-delimited samples.
  function automatic void model_in(input int sel, input logic [15:0] iv,
                                   input logic [15:0] qv, input logic sopv);
    int cp;
    int idx;
    smp_t s;
    cp = (sel == 0) ? 4 : 16;
    if (sopv) begin
      if (cnt[sel] != 0) begin
        exp_sync_n++;
        exp_sync_cyc = cyc;
      end
      cnt[sel] = 0;
    end else if (cnt[sel] == 0) begin
      return;
    end
    sbuf[sel][cnt[sel]] = {iv, qv};
    cnt[sel]++;
    if (cnt[sel] == N) begin
      for (int k = 0; k < cp + N; k++) begin
        idx   = (k < cp) ? (N - cp + k) : (k - cp);
        s.i   = sbuf[sel][idx][31:16];
        s.q   = sbuf[sel][idx][15:0];
        s.sop = (k == 0);
        s.eop = (k == cp + N - 1);
        if (sel == 0) qa.push_back(s);
        else          qb.push_back(s);
      end
      cnt[sel] = 0;
    end
  endfunction

  // Present one sample. The task is entered and left at posedge+1.
  task automatic put(input int sel, input logic [15:0] iv, input logic sopv);
    int w;
    w = 0;
    while (!((sel == 0) ? rdy_a : rdy_b)) begin
      va = 1'b0; vb = 1'b0;
      stalls++;
      @(posedge clk); #1;
      w++;
      if (w > 200) begin
        chk("ready_timeout", 64'(w), 64'(0));
        return;
      end
    end
    i_in = iv; q_in = -iv; sop_in = sopv;
    va = (sel == 0); vb = (sel == 1);
    @(posedge clk); #1;
    model_in(sel, iv, -iv, sopv);
    last_acc = cyc;
    va = 1'b0; vb = 1'b0; sop_in = 1'b0;
  endtask

  task automatic send(input int sel, input int off);
    for (int k = 0; k < N; k++) put(sel, 16'(off + k), k == 0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((qa.size() != 0 || qb.size() != 0) && w < 3000) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_a", 64'(qa.size()), 64'(0));
    chk("drain_b", 64'(qb.size()), 64'(0));
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_ok <= ready_in & en;
  end

  always @(negedge clk) begin
    smp_t e;
    if (res) begin
      if (!prev_ok) begin
        chk("vld_after_stall_a", 64'(vo_a), 64'(0));
        chk("vld_after_stall_b", 64'(vo_b), 64'(0));
      end
      if (vo_a) begin
        seen_a++;
        run++;
        if (first_a < 0) first_a = cyc;
        if (qa.size() == 0) chk("extra_out_a", 64'(1), 64'(0));
        else begin
          e = qa.pop_front();
          chk("data_a", {io_a, qo_a}, {e.i, e.q});
          chk("flags_a", {so_a, eo_a}, {e.sop, e.eop});
        end
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      if (vo_b) begin
        if (qb.size() == 0) chk("extra_out_b", 64'(1), 64'(0));
        else begin
          e = qb.pop_front();
          chk("data_b", {io_b, qo_b}, {e.i, e.q});
          chk("flags_b", {so_b, eo_b}, {e.sop, e.eop});
        end
      end
      if (se_a | se_b) begin
        sync_seen++;
        sync_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, base, o1, o2;
    cnt[0] = 0; cnt[1] = 0;

    // Reset state
    #13;
    chk("rst_flags_a", {vo_a, so_a, eo_a, se_a}, 0);
    chk("rst_data_a", {io_a, qo_a}, 0);
    chk("rst_ready_a", 64'(rdy_a), 64'(1));
    chk("rst_flags_b", {vo_b, so_b, eo_b, se_b}, 0);
    chk("rst_ready_b", 64'(rdy_b), 64'(1));
    @(negedge clk) res = 1'b1;
    @(posedge clk); #1;

    // 1: single symbol and its latency
    first_a = -1;
    send(0, 0);
    drain();
    chk("latency", 64'(first_a - last_acc), 64'(2));

    // 2: three back-to-back symbols
    maxrun = 0; stalls = 0;
    for (int n = 0; n < 3; n++) send(0, 100 * n);
    drain();
    chk("ready_dropped", 64'(stalls > 0), 64'(1));
    chk("run60", 64'(maxrun), 64'(60));

    // 3: random ready_in and en during playout
    ready_in = 1'b0;
    send(0, 0);
    w = 0;
    while (qa.size() != 0 && w < 4000) begin
      @(negedge clk);
      ready_in = 1'($urandom_range(0, 1));
      en       = ($urandom_range(0, 7) != 0);
      w++;
    end
    @(negedge clk); ready_in = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    drain();

    // 4: resync at input sample 7
    o1 = $urandom_range(0, 9000);
    o2 = $urandom_range(10000, 20000);
    sync_seen = 0; exp_sync_n = 0;
    for (int k = 0; k < 7; k++) put(0, 16'(o1 + k), k == 0);
    send(0, o2);
    drain();
    chk("sync_count", 64'(sync_seen), 64'(exp_sync_n));
    chk("sync_once", 64'(sync_seen), 64'(1));
    chk("sync_cycle", 64'(sync_cyc), 64'(exp_sync_cyc));

    // 5: reset during playout, then a clean symbol
    base = seen_a;
    send(0, $urandom_range(0, 30000));
    w = 0;
    while (seen_a - base < 9 && w < 200) begin
      @(negedge clk); #2;
      w++;
    end
    chk("reached_sample9", 64'(seen_a - base), 64'(9));
    res = 1'b0;
    #1;
    qa.delete(); qb.delete(); cnt[0] = 0; cnt[1] = 0;
    chk("rst_mid_flags_a", {vo_a, so_a, eo_a, se_a}, 0);
    chk("rst_mid_data_a", {io_a, qo_a}, 0);
    chk("rst_mid_ready_a", 64'(rdy_a), 64'(1));
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_a", {vo_a, so_a, eo_a, se_a, io_a, qo_a}, 0);
    end
    @(negedge clk) res = 1'b1;
    @(posedge clk); #1;
    send(0, $urandom_range(0, 30000));
    drain();

    // 6: CP_LEN = OFDM_SIZE
    send(1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
